// File: rtl/adc_pkg.sv
// Shared constants for the synchronous ADC capture slice: FSM encodings,
// default sample width and the minimum accumulator width helper.
package adc_pkg;

  localparam int unsigned ADC_BITS_DEF = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Smallest signed accumulator that cannot wrap over a nominal period.
  function automatic int unsigned acc_w_min(input int unsigned bits, input int unsigned n);
    return bits + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adc_spi_rx.sv
// Serial read of one ADC sample: chip select, divided sclk and MSB-first
// shift register, with a start/busy/done handshake toward the top.
module adc_spi_rx
  import adc_pkg::*;
#(
  parameter int unsigned ADC_BITS = ADC_BITS_DEF,
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                adc_sdo,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                busy,
  output logic                done_c,
  output logic [ADC_BITS-1:0] data
);

  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BIT_W = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

  logic [1:0]          state, state_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [BIT_W-1:0]    bitc, bitc_n;
  logic                sclk_q, sclk_n;
  logic                cs_n_q, cs_n_n;
  logic                busy_q, busy_n;
  logic [ADC_BITS-1:0] shreg, shreg_n;
  logic                div_last, bit_last;

  assign div_last = (div == DIV_W'(SCLK_DIV - 1));
  assign bit_last = (bitc == BIT_W'(ADC_BITS - 1));

  // State and registered interface outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      div    <= '0;
      bitc   <= '0;
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      div    <= div_n;
      bitc   <= bitc_n;
      sclk_q <= sclk_n;
      cs_n_q <= cs_n_n;
      busy_q <= busy_n;
      shreg  <= shreg_n;
    end
  end

  // Next state; every phase lasts SCLK_DIV cycles, data captured as sclk rises
  always_comb begin
    state_n = state;
    div_n   = div;
    bitc_n  = bitc;
    sclk_n  = sclk_q;
    cs_n_n  = cs_n_q;
    busy_n  = busy_q;
    shreg_n = shreg;
    done_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SETUP;
          cs_n_n  = 1'b0;
          busy_n  = 1'b1;
          div_n   = '0;
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_n = ST_SHIFT;
          div_n   = '0;
          bitc_n  = '0;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!div_last) begin
          div_n = div + DIV_W'(1);
        end else if (!sclk_q) begin
          div_n   = '0;
          sclk_n  = 1'b1;
          shreg_n = {shreg[ADC_BITS-2:0], adc_sdo};
        end else begin
          div_n  = '0;
          sclk_n = 1'b0;
          if (bit_last) begin
            state_n = ST_HOLD;
          end else begin
            bitc_n = bitc + BIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          state_n = ST_IDLE;
          div_n   = '0;
          cs_n_n  = 1'b1;
          busy_n  = 1'b0;
          done_c  = 1'b1;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cs_n_n  = 1'b1;
        busy_n  = 1'b0;
        sclk_n  = 1'b0;
      end
    endcase
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign busy     = busy_q;
  assign data     = shreg;

endmodule

// File: rtl/adc_sync_capture.sv
// Lock-in capture: one SPI ADC read per start_conv edge, each sample signed by
// the stimulus half and summed over one stimulus period.
module adc_sync_capture
  import adc_pkg::*;
#(
  parameter int unsigned ADC_BITS           = ADC_BITS_DEF,
  parameter int unsigned SCLK_DIV           = 4,
  parameter int unsigned SAMPLES_PER_PERIOD = 32,
  parameter int unsigned ACC_W              = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_conv,
  input  logic                    new_period,
  input  logic                    phaze,
  input  logic                    adc_sdo,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic [ADC_BITS-1:0]     sample,
  output logic                    sample_valid,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  output logic                    result_err,
  output logic                    overrun,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_PERIOD + 1);

  logic                    start_conv_d;
  logic                    start_edge_c;
  logic                    accept_c;
  logic                    ph_l, first_l, armed;
  logic                    rx_busy, rx_done_c;
  logic [ADC_BITS-1:0]     rx_data;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] mag_c, term_c;

  assign start_edge_c = start_conv & ~start_conv_d;
  assign accept_c     = start_edge_c & ~rx_busy;

  adc_spi_rx #(
    .ADC_BITS (ADC_BITS),
    .SCLK_DIV (SCLK_DIV)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .start    (accept_c),
    .adc_sdo  (adc_sdo),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .busy     (rx_busy),
    .done_c   (rx_done_c),
    .data     (rx_data)
  );

  // Sample signed by the stimulus half latched at conversion start
  always_comb begin
    mag_c  = ACC_W'(rx_data);
    term_c = ph_l ? mag_c : -mag_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_conv_d <= 1'b0;
      ph_l         <= 1'b0;
      first_l      <= 1'b0;
      armed        <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      start_conv_d <= start_conv;
      sample_valid <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= start_edge_c & rx_busy;
      if (accept_c) begin
        ph_l    <= phaze;
        first_l <= new_period;
      end
      if (rx_done_c) begin
        sample       <= rx_data;
        sample_valid <= 1'b1;
        // First sample of a period closes the previous one, if it was armed
        if (first_l) begin
          if (armed) begin
            result       <= acc;
            result_err   <= (cnt != CNT_W'(SAMPLES_PER_PERIOD));
            result_valid <= 1'b1;
          end
          armed <= 1'b1;
          acc   <= term_c;
          cnt   <= CNT_W'(1);
        end else begin
          acc <= acc + term_c;
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy = rx_busy;

endmodule
